// File: rtl/iq_pkg.sv
// Shared parameters, FU encoding and entry layout for the compacting issue queue.
package iq_pkg;
  localparam int DEPTH  = 16;
  localparam int NUM_FU = 4;
  localparam int TAG_W  = 6;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_MEM, FU_BR} fu_e;

  typedef struct packed {
    logic             vld;
    fu_e              fu;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] src_tag;
    logic             rdy;
  } iq_entry_t;
endpackage

// File: rtl/iq_oldest_select.sv
// Finds the lowest-index (oldest) set bit of a request vector.
module iq_oldest_select
  import iq_pkg::*;
(
  input  logic [DEPTH-1:0] req_i,
  output logic             found_o,
  output logic [DEPTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  assign found_o  = |req_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (-req_i);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (onehot_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/issue_queue_scheduler.sv
// Compacting issue queue: per-FU oldest-ready select, compaction, dual dispatch and
// tag wakeup, all resolved on a single clock edge.
module issue_queue_scheduler
  import iq_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          disp_1_vld_i,
  input  logic                          disp_2_vld_i,
  input  logic [1:0]                    disp_1_fu_i,
  input  logic [1:0]                    disp_2_fu_i,
  input  logic [TAG_W-1:0]              disp_1_tag_i,
  input  logic [TAG_W-1:0]              disp_2_tag_i,
  input  logic [TAG_W-1:0]              disp_1_src_tag_i,
  input  logic [TAG_W-1:0]              disp_2_src_tag_i,
  input  logic                          disp_1_rdy_i,
  input  logic                          disp_2_rdy_i,
  input  logic                          wake_vld_i,
  input  logic [TAG_W-1:0]              wake_tag_i,
  input  logic [NUM_FU-1:0]             fu_busy_i,
  output logic [NUM_FU-1:0]             issue_vld_o,
  output logic [NUM_FU-1:0][TAG_W-1:0]  issue_tag_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          disp_stall_o
);

  iq_entry_t [DEPTH-1:0]          ent_q, ent_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [NUM_FU-1:0]              issue_vld_q, issue_vld_d;
  logic [NUM_FU-1:0][TAG_W-1:0]   issue_tag_q, issue_tag_d;

  logic [NUM_FU-1:0][DEPTH-1:0]   req;
  logic [NUM_FU-1:0][DEPTH-1:0]   onehot;
  logic [NUM_FU-1:0]              found;
  logic [NUM_FU-1:0][IDX_W-1:0]   sel_idx;
  logic [DEPTH-1:0]               issued;
  logic [CNT_W-1:0]               n_issued;
  logic [CNT_W-1:0]               base;
  logic [IDX_W-1:0]               shift_cnt;
  logic                           stall;
  logic                           acc_1, acc_2;

  // Stall looks only at registered count, so a same-cycle issue never frees a slot.
  assign stall = (count_q >= CNT_W'(DEPTH - 1));

  always_comb begin
    req = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        req[f][i] = ent_q[i].vld & ent_q[i].rdy & (ent_q[i].fu == fu_e'(f)) & ~fu_busy_i[f];
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    iq_oldest_select u_sel (
      .req_i   (req[f]),
      .found_o (found[f]),
      .onehot_o(onehot[f]),
      .idx_o   (sel_idx[f])
    );
  end

  always_comb begin
    issued = '0;
    for (int f = 0; f < NUM_FU; f++) issued = issued | onehot[f];

    n_issued = '0;
    for (int i = 0; i < DEPTH; i++) n_issued = n_issued + CNT_W'(issued[i]);
    base = count_q - n_issued;

    // Compaction: each survivor moves down by the number of grants below it.
    ent_d     = '0;
    shift_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].vld && !issued[i]) ent_d[IDX_W'(i) - shift_cnt] = ent_q[i];
      shift_cnt = shift_cnt + IDX_W'(issued[i]);
    end

    acc_1 = disp_1_vld_i & ~stall;
    acc_2 = acc_1 & disp_2_vld_i;
    if (acc_1) begin
      ent_d[base[IDX_W-1:0]] = '{vld: 1'b1, fu: fu_e'(disp_1_fu_i), tag: disp_1_tag_i,
                                 src_tag: disp_1_src_tag_i, rdy: disp_1_rdy_i};
    end
    if (acc_2) begin
      ent_d[base[IDX_W-1:0] + IDX_W'(1)] = '{vld: 1'b1, fu: fu_e'(disp_2_fu_i), tag: disp_2_tag_i,
                                             src_tag: disp_2_src_tag_i, rdy: disp_2_rdy_i};
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (wake_vld_i && ent_d[i].vld && (ent_d[i].src_tag == wake_tag_i)) ent_d[i].rdy = 1'b1;
    end

    count_d = base + CNT_W'(acc_1) + CNT_W'(acc_2);

    for (int f = 0; f < NUM_FU; f++) begin
      issue_vld_d[f] = found[f];
      issue_tag_d[f] = found[f] ? ent_q[sel_idx[f]].tag : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q       <= '0;
      count_q     <= '0;
      issue_vld_q <= '0;
      issue_tag_q <= '0;
    end else begin
      ent_q       <= ent_d;
      count_q     <= count_d;
      issue_vld_q <= issue_vld_d;
      issue_tag_q <= issue_tag_d;
    end
  end

  assign issue_vld_o  = issue_vld_q;
  assign issue_tag_o  = issue_tag_q;
  assign count_o      = count_q;
  assign disp_stall_o = stall;

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Table-driven bench for issue_queue_scheduler; expected outputs queued at drive time
// and compared one cycle later, plus an asynchronous mid-stream reset sequence.
module tb_issue_queue_scheduler;
  import iq_pkg::*;

  typedef struct packed {
    logic       v;
    logic [1:0] fu;
    logic [5:0] tag;
    logic [5:0] src;
    logic       rdy;
  } disp_t;

  typedef struct packed {
    logic [3:0]  vld;
    logic [23:0] tags;
    logic [4:0]  cnt;
    logic        stall;
  } exp_t;

  typedef struct packed {
    disp_t      d1;
    disp_t      d2;
    logic       wv;
    logic [5:0] wt;
    logic [3:0] busy;
    exp_t       e;
  } vec_t;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic                         disp_1_vld_i, disp_2_vld_i;
  logic [1:0]                   disp_1_fu_i, disp_2_fu_i;
  logic [TAG_W-1:0]             disp_1_tag_i, disp_2_tag_i;
  logic [TAG_W-1:0]             disp_1_src_tag_i, disp_2_src_tag_i;
  logic                         disp_1_rdy_i, disp_2_rdy_i;
  logic                         wake_vld_i;
  logic [TAG_W-1:0]             wake_tag_i;
  logic [NUM_FU-1:0]            fu_busy_i;
  logic [NUM_FU-1:0]            issue_vld_o;
  logic [NUM_FU-1:0][TAG_W-1:0] issue_tag_o;
  logic [CNT_W-1:0]             count_o;
  logic                         disp_stall_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  exp_t sb[$];

  issue_queue_scheduler dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .disp_1_vld_i    (disp_1_vld_i),
    .disp_2_vld_i    (disp_2_vld_i),
    .disp_1_fu_i     (disp_1_fu_i),
    .disp_2_fu_i     (disp_2_fu_i),
    .disp_1_tag_i    (disp_1_tag_i),
    .disp_2_tag_i    (disp_2_tag_i),
    .disp_1_src_tag_i(disp_1_src_tag_i),
    .disp_2_src_tag_i(disp_2_src_tag_i),
    .disp_1_rdy_i    (disp_1_rdy_i),
    .disp_2_rdy_i    (disp_2_rdy_i),
    .wake_vld_i      (wake_vld_i),
    .wake_tag_i      (wake_tag_i),
    .fu_busy_i       (fu_busy_i),
    .issue_vld_o     (issue_vld_o),
    .issue_tag_o     (issue_tag_o),
    .count_o         (count_o),
    .disp_stall_o    (disp_stall_o)
  );

  always #5 clk_i = ~clk_i;

  localparam disp_t NONE = '0;

  function automatic disp_t D(input int fu, input int tag, input int src, input int rdy);
    disp_t d;
    d.v   = 1'b1;
    d.fu  = 2'(fu);
    d.tag = 6'(tag);
    d.src = 6'(src);
    d.rdy = rdy[0];
    return d;
  endfunction

  function automatic exp_t E(input int vld, input int t0, input int t1, input int t2,
                             input int t3, input int cnt, input int st);
    exp_t e;
    e.vld   = 4'(vld);
    e.tags  = {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    e.cnt   = 5'(cnt);
    e.stall = st[0];
    return e;
  endfunction

  // wt < 0 means no wakeup broadcast in that cycle.
  function automatic void add(input disp_t d1, input disp_t d2, input int wt, input int busy,
                              input exp_t e);
    vec_t v;
    v.d1   = d1;
    v.d2   = d2;
    v.wv   = (wt >= 0);
    v.wt   = 6'(wt);
    v.busy = 4'(busy);
    v.e    = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    disp_1_vld_i = 1'b0; disp_1_fu_i = '0; disp_1_tag_i = '0; disp_1_src_tag_i = '0; disp_1_rdy_i = 1'b0;
    disp_2_vld_i = 1'b0; disp_2_fu_i = '0; disp_2_tag_i = '0; disp_2_src_tag_i = '0; disp_2_rdy_i = 1'b0;
    wake_vld_i = 1'b0; wake_tag_i = '0; fu_busy_i = '0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    exp_t e;
    disp_1_vld_i = v.d1.v; disp_1_fu_i = v.d1.fu; disp_1_tag_i = v.d1.tag;
    disp_1_src_tag_i = v.d1.src; disp_1_rdy_i = v.d1.rdy;
    disp_2_vld_i = v.d2.v; disp_2_fu_i = v.d2.fu; disp_2_tag_i = v.d2.tag;
    disp_2_src_tag_i = v.d2.src; disp_2_rdy_i = v.d2.rdy;
    wake_vld_i = v.wv; wake_tag_i = v.wt; fu_busy_i = v.busy;
    sb.push_back(v.e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check($sformatf("row%0d issue_vld", idx), 32'(issue_vld_o), 32'(e.vld));
    check($sformatf("row%0d issue_tag", idx), 32'(issue_tag_o), 32'(e.tags));
    check($sformatf("row%0d count", idx), 32'(count_o), 32'(e.cnt));
    check($sformatf("row%0d disp_stall", idx), 32'(disp_stall_o), 32'(e.stall));
  endtask

  initial begin
    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset issue_vld", 32'(issue_vld_o), 32'd0);
    check("reset issue_tag", 32'(issue_tag_o), 32'd0);
    check("reset count", 32'(count_o), 32'd0);
    check("reset disp_stall", 32'(disp_stall_o), 32'd0);
    rst_ni = 1'b1;

    // Two ready dispatches, granted two cycles later.
    add(D(FU_ALU, 5, 0, 1), D(FU_MUL, 6, 0, 1), -1, 0, E(4'b0000, 0, 0, 0, 0, 2, 0));
    add(NONE, NONE, -1, 0, E(4'b0011, 5, 6, 0, 0, 0, 0));
    add(NONE, NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 0, 0));
    // Four ready ALU ops drain in age order, one per cycle; ALU busy holds them.
    add(D(FU_ALU, 10, 0, 1), D(FU_ALU, 11, 0, 1), -1, 0, E(4'b0000, 0, 0, 0, 0, 2, 0));
    add(D(FU_ALU, 12, 0, 1), D(FU_ALU, 13, 0, 1), -1, 0, E(4'b0001, 10, 0, 0, 0, 3, 0));
    add(NONE, NONE, -1, 4'b0001, E(4'b0000, 0, 0, 0, 0, 3, 0));
    add(NONE, NONE, -1, 4'b1110, E(4'b0001, 11, 0, 0, 0, 2, 0));
    add(NONE, NONE, -1, 0, E(4'b0001, 12, 0, 0, 0, 1, 0));
    add(NONE, NONE, -1, 0, E(4'b0001, 13, 0, 0, 0, 0, 0));
    add(NONE, NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 0, 0));
    // Wakeup: wrong tag ignored, matching tag grants two cycles after the wake.
    add(D(FU_ALU, 20, 9, 0), NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 1, 0));
    add(NONE, NONE, 8, 0, E(4'b0000, 0, 0, 0, 0, 1, 0));
    add(NONE, NONE, 9, 0, E(4'b0000, 0, 0, 0, 0, 1, 0));
    add(NONE, NONE, -1, 0, E(4'b0001, 20, 0, 0, 0, 0, 0));
    add(D(FU_MUL, 21, 7, 0), NONE, 7, 0, E(4'b0000, 0, 0, 0, 0, 1, 0));
    add(NONE, NONE, -1, 0, E(4'b0010, 0, 21, 0, 0, 0, 0));
    // Simultaneous issue of two, dispatch of two and a wake in one cycle.
    add(D(FU_ALU, 30, 0, 1), D(FU_BR, 31, 3, 0), -1, 4'b0011, E(4'b0000, 0, 0, 0, 0, 2, 0));
    add(D(FU_MUL, 32, 0, 1), D(FU_MEM, 33, 4, 0), -1, 4'b0011, E(4'b0000, 0, 0, 0, 0, 4, 0));
    add(D(FU_BR, 34, 3, 0), D(FU_ALU, 35, 0, 1), 3, 0, E(4'b0011, 30, 32, 0, 0, 4, 0));
    add(NONE, NONE, -1, 0, E(4'b1001, 35, 0, 0, 31, 2, 0));
    add(NONE, NONE, 4, 0, E(4'b1000, 0, 0, 0, 34, 1, 0));
    add(NONE, NONE, -1, 0, E(4'b0100, 0, 0, 33, 0, 0, 0));
    // disp_2 alone is ignored.
    add(NONE, D(FU_ALU, 36, 0, 1), -1, 0, E(4'b0000, 0, 0, 0, 0, 0, 0));
    add(NONE, NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 0, 0));
    // Fill to 16, stalled dispatches dropped, full-queue select and stall release.
    for (int k = 0; k < 6; k++) begin
      add(D(FU_ALU, 40 + 2 * k, 1, 0), D(FU_ALU, 41 + 2 * k, 1, 0), -1, 0,
          E(4'b0000, 0, 0, 0, 0, 2 * k + 2, 0));
    end
    add(D(FU_ALU, 52, 1, 0), NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 13, 0));
    add(D(FU_ALU, 53, 1, 0), NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 14, 0));
    add(D(FU_ALU, 54, 1, 0), D(FU_ALU, 55, 1, 0), -1, 0, E(4'b0000, 0, 0, 0, 0, 16, 1));
    add(D(FU_ALU, 60, 1, 1), D(FU_ALU, 61, 1, 1), -1, 0, E(4'b0000, 0, 0, 0, 0, 16, 1));
    add(NONE, NONE, 1, 0, E(4'b0000, 0, 0, 0, 0, 16, 1));
    add(D(FU_ALU, 62, 0, 1), D(FU_ALU, 63, 0, 1), -1, 0, E(4'b0001, 40, 0, 0, 0, 15, 1));
    add(D(FU_ALU, 62, 0, 1), D(FU_ALU, 63, 0, 1), -1, 0, E(4'b0001, 41, 0, 0, 0, 14, 0));

    for (int r = 0; r < tbl.size(); r++) run_row(r, tbl[r]);

    // Asynchronous reset mid-stream while an issue is still visible.
    drive_idle();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async rst issue_vld", 32'(issue_vld_o), 32'd0);
    check("async rst issue_tag", 32'(issue_tag_o), 32'd0);
    check("async rst count", 32'(count_o), 32'd0);
    check("async rst disp_stall", 32'(disp_stall_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    tbl.delete();
    add(D(FU_ALU, 7, 0, 1), NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 1, 0));
    add(NONE, NONE, -1, 0, E(4'b0001, 7, 0, 0, 0, 0, 0));
    add(NONE, NONE, -1, 0, E(4'b0000, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < tbl.size(); r++) run_row(100 + r, tbl[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_queue_scheduler.md
# issue_queue_scheduler

Scheduler and storage controller for the 16-entry compacting issue queue. Each cycle it accepts up to two dispatched instructions, wakes waiting entries on a result-tag broadcast, and selects at most one oldest-ready instruction per functional unit (4 FUs). It compacts the queue after issue and appends new entries at the tail. Sits between dispatch and the FU issue ports; its per-FU issue grants are the queue's leave signals.

## Interface
- DEPTH, 16, queue entries; index 0 is oldest
- NUM_FU, 4, functional units, one issue port each
- TAG_W, 6, width of destination/source tags
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- disp_1_vld, disp_2_vld  in  1  dispatch requests; disp_2 honoured only with disp_1
- disp_1_fu, disp_2_fu  in  2  target FU type (fu_e)
- disp_1_tag, disp_2_tag  in  TAG_W  destination tag
- disp_1_src_tag, disp_2_src_tag  in  TAG_W  outstanding source tag
- disp_1_rdy, disp_2_rdy  in  1  operands already available
- wake_vld  in  1  result broadcast valid
- wake_tag  in  TAG_W  broadcast tag
- fu_busy  in  NUM_FU  FU f cannot accept an issue this cycle
- issue_vld  out  NUM_FU  registered per-FU grant
- issue_tag  out  NUM_FU x TAG_W  registered destination tag per grant
- count  out  5  occupied entries, 0..16
- disp_stall  out  1  fewer than 2 free entries

## Operation
- Entry state: vld, fu[1:0], tag, src_tag, rdy. Valid entries are always contiguous from index 0 in age order.
- Select:
  - For each FU f with fu_busy[f]=0, pick the lowest index i with vld & rdy & fu==f.
  - Selection uses registered state only.
  - At most one grant per FU per cycle, up to 4 total.
- Issue: the selected entries are removed at the clock edge. Surviving entries shift down, preserving relative order, so entry i moves to i minus the number of selected entries below i.
- Dispatch:
  - Accepted only when disp_stall=0.
  - disp_1 is written at index count − n_issued; disp_2 at that index +1.
  - A disp_2_vld without disp_1_vld is ignored.
  - A stalled dispatch is dropped; upstream must hold and retry.
- Wakeup:
  - When wake_vld=1, every valid entry with src_tag==wake_tag sets rdy.
  - This applies to surviving entries and to entries dispatched in the same cycle (rdy_new = disp_rdy | wake match).
  - An entry woken in cycle t is first selectable in cycle t+1.
- Count: count_next = count − n_issued + n_dispatched. All arithmetic is 5-bit unsigned, and count never exceeds 16.
- disp_stall = (count ≥ DEPTH−1), computed from registered count. This is conservative: issuing in the same cycle does not release the stall.
- Reset (rst=0, async): all vld=0, rdy=0, count=0, issue_vld=0, issue_tag=0, disp_stall=0. Reset during dispatch or issue discards everything, with no partial state.

## Timing
- Issue latency: an entry ready in cycle t has its issue_vld/issue_tag asserted in cycle t+1. The entry is absent from the queue in t+1.
- Dispatch-to-issue:
  - An entry with rdy=1 dispatched in cycle t is selectable in t+1.
  - Its grant is visible in t+2.
- count and disp_stall update on the same edge as removal and append.
- Simultaneous dispatch, issue and wakeup in one cycle:
  - Compaction happens first, then append, then wake matching on the final contents.
  - All three are resolved in a single edge.
- Full queue (count=16): disp_stall=1, and selection proceeds normally.
- Empty queue: issue_vld=0 next cycle regardless of fu_busy.
- No pointer wrap: the queue is compacting, and the tail index equals count.

## Structure
- Package iq_pkg holds:
  - DEPTH, NUM_FU, TAG_W
  - typedef enum logic [1:0] fu_e {FU_ALU, FU_MUL, FU_MEM, FU_BR}
  - typedef struct iq_entry_t {vld, fu, tag, src_tag, rdy}
- Sub-module iq_oldest_select, instantiated NUM_FU times. Input is a DEPTH-bit request vector; outputs are a found flag and a one-hot / 4-bit index of the lowest set bit.
- Compaction is a per-entry prefix count of issued entries plus a shift mux, implemented inline in the top level.

## Test plan
- Reset, then dispatch ALU (tag 5, rdy=1) and MUL (tag 6, rdy=1) in cycle 1 → cycle 3: issue_vld=0011, tags 5/6; count goes 0→2→0.
- Fill the queue with 16 non-ready ALU entries → disp_stall=1 once count=15. A 17th dispatch is dropped and count stays 16.
- Entries 0..3 all ALU and ready, fu_busy=0 → one issue per cycle in age order (0,1,2,3), with remaining entries compacting each cycle.
- Entry waiting on src_tag 9, then wake_vld with tag 9 → issue_vld asserted exactly 2 cycles after the wake cycle.
- Same cycle: issue 2 entries, dispatch 2, wake 1 → count unchanged; new entries land at the old count−2 and count−1; order is preserved.
- Assert rst mid-stream with count=7 → count=0 and issue_vld=0 immediately. The first post-reset dispatch lands at index 0.
